mux_rr_arbiter: RTL and testbench
=================================

// Module: mux_rr_arbiter
// PURPOSE
//  Round-robin arbiter sharing one 4:1 W-bit mux datapath (mux_2s) among four requesters.
//  Registers the grant, drives the mux select, presents the selected word on a valid/ready
//  output and pulses a per-requester ack on transfer. Sits between producers and one consumer.
// PARAMETERS
//  W   4   data width of each requester word and of out_data
//  CW  8   width of transfer counter xfer_cnt
// PORTS
//  clk        in   1     rising-edge clock
//  rst_n      in   1     synchronous reset, active-low
//  req        in   4     req[i]=1: requester i has a word on d<i>
//  d0..d3     in   W     requester data, stable while req[i]=1
//  lock       in   4     burst lock per requester (present only with MUX_ARB_LOCK_EN)
//  out_ready  in   1     consumer accepts out_data this cycle
//  out_valid  out  1     out_data valid
//  out_data   out  W     selected word, 0 when out_valid=0
//  gnt        out  4     one-hot registered grant, 0 in IDLE
//  sel        out  2     registered mux select = index of gnt
//  ack        out  4     ack[i]=gnt[i]&out_ready&out_valid, combinational
//  xfer_cnt   out  CW    completed transfers, wraps modulo 2^CW
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): state=IDLE, gnt=0, sel=0, out_valid=0, out_data=0,
//    xfer_cnt=0, last=3 (so requester 0 has top priority after reset). Overrides all else.
//  - FSM IDLE: if req!=0, pick first set req scanning last+1, last+2, ... (mod 4);
//    load gnt/sel, go GRANT next edge. req=0: stay IDLE. Latency req->out_valid = 1 cycle.
//  - FSM GRANT: out_valid=1, out_data=d[sel] via mux_2s instance driven by sel.
//    out_valid&&out_ready: transfer; ack[sel]=1 same cycle; last<=sel; xfer_cnt+=1;
//    go IDLE (one bubble cycle between grants; requester must drop req the cycle after ack
//    unless it has another word).
//    out_ready=0: hold gnt/sel/out_data, no ack; grant is never pre-empted by other reqs.
//    req[sel]=0 while in GRANT (protocol violation): abort to IDLE, no ack, no count,
//    last unchanged.
//  - Fairness: with all four req held high, grant order 0,1,2,3,0,... ; a continuously
//    requesting source waits at most 3 transfers.
//  - xfer_cnt wraps 2^CW-1 -> 0 with no flag.
//  - gnt one-hot or zero at all times; sel only changes on IDLE->GRANT or reset.
// CONFIGURATION
//  MUX_ARB_LOCK_EN defined: lock port exists. On transfer with lock[sel]=1 and req[sel]=1
//    the FSM stays in GRANT with same gnt/sel (back-to-back, no bubble); last not updated
//    until the transfer with lock[sel]=0. lock of non-granted requesters ignored.
//  MUX_ARB_LOCK_EN undefined: no lock port; every transfer returns to IDLE as above.
// TESTING
//  1 Reset: rst_n=0 2 cycles with req=4'hF -> gnt=0,out_valid=0,xfer_cnt=0; release ->
//    first grant to requester 0 one cycle later, out_data=d0.
//  2 Single: d2=4'b0100, req=4'b0100, out_ready=1 -> cycle+1 gnt=4'b0100,sel=2,
//    out_data=0100, ack=4'b0100; next cycle IDLE; xfer_cnt=1.
//  3 Round-robin: req=4'hF held, d0..d3=1,2,4,8, out_ready=1 -> out_data sequence
//    0001,0010,0100,1000,0001 on alternate cycles; xfer_cnt=5.
//  4 Backpressure: grant to 1, out_ready=0 for 5 cycles while req=4'hF -> gnt=4'b0010,
//    out_data=d1 stable, ack=0; out_ready=1 -> one ack[1], next grant to 2.
//  5 Abort/reset mid-op: in GRANT drop req[sel] -> IDLE, no ack, xfer_cnt unchanged;
//    rst_n=0 during GRANT -> outputs to reset values next edge, next grant to 0.
//  6 Lock (MUX_ARB_LOCK_EN): lock[3]=1, req=4'b1001, 3 transfers -> gnt=4'b1000 each,
//    no bubble; lock[3]=0 on 4th -> IDLE, next grant to 0; xfer_cnt=4.

Source files
------------

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: four-requester round-robin arbiter in front of a shared
// 4:1 W-bit mux. The grant and mux select are registered. The selected word
// is presented on a valid/ready output, and each requester receives an ack
// pulse when its word transfers.
// Optional burst lock is enabled by defining MUX_ARB_LOCK_EN, which adds the
// lock port.

// mux_2s: plain 4:1 W-bit multiplexer driven by a 2-bit select.
module mux_2s #(
  parameter int unsigned W = 4
) (
  input  logic [1:0]   i_sel,
  input  logic [W-1:0] i_d0,
  input  logic [W-1:0] i_d1,
  input  logic [W-1:0] i_d2,
  input  logic [W-1:0] i_d3,
  output logic [W-1:0] o_d
);

  // select one of the four input words
  always_comb begin
    o_d = '0;
    unique case (i_sel)
      2'd0: o_d = i_d0;
      2'd1: o_d = i_d1;
      2'd2: o_d = i_d2;
      2'd3: o_d = i_d3;
      default: o_d = '0;
    endcase
  end

endmodule

module mux_rr_arbiter #(
  parameter int unsigned W  = 4,
  parameter int unsigned CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [3:0]    req,
  input  logic [W-1:0]  d0,
  input  logic [W-1:0]  d1,
  input  logic [W-1:0]  d2,
  input  logic [W-1:0]  d3,
`ifdef MUX_ARB_LOCK_EN
  input  logic [3:0]    lock,
`endif
  input  logic          out_ready,
  output logic          out_valid,
  output logic [W-1:0]  out_data,
  output logic [3:0]    gnt,
  output logic [1:0]    sel,
  output logic [3:0]    ack,
  output logic [CW-1:0] xfer_cnt
);

  typedef enum logic {
    ST_IDLE,
    ST_GRANT
  } state_t;

  state_t        r_state;
  logic [3:0]    r_gnt;
  logic [1:0]    r_sel;
  logic [1:0]    r_last;
  logic          r_valid;
  logic [CW-1:0] r_cnt;

  logic [1:0]    w_pick_idx;
  logic          w_pick_found;
  logic          w_xfer;
  logic          w_hold;
  logic [W-1:0]  w_mux_d;

  mux_2s #(.W(W)) u_mux (
    .i_sel (r_sel),
    .i_d0  (d0),
    .i_d1  (d1),
    .i_d2  (d2),
    .i_d3  (d3),
    .o_d   (w_mux_d)
  );

  // round-robin pick: first active request scanning last+1, last+2, ... mod 4
  always_comb begin
    w_pick_found = 1'b0;
    w_pick_idx   = '0;
    for (int unsigned k = 1; k <= 4; k++) begin
      if (!w_pick_found && req[r_last + 2'(k)]) begin
        w_pick_found = 1'b1;
        w_pick_idx   = r_last + 2'(k);
      end
    end
  end

  // A transfer also requires the granted request to still be asserted.
  // If that request has dropped, the grant is aborted, so no ack is issued.
  assign w_xfer = r_valid & out_ready & req[r_sel];

`ifdef MUX_ARB_LOCK_EN
  assign w_hold = lock[r_sel];
`else
  assign w_hold = 1'b0;
`endif

  assign out_valid = r_valid;
  assign out_data  = r_valid ? w_mux_d : '0;
  assign gnt       = r_gnt;
  assign sel       = r_sel;
  assign ack       = r_gnt & {4{w_xfer}};
  assign xfer_cnt  = r_cnt;

  // arbitration FSM with registered grant, select, valid and transfer count
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_gnt   <= '0;
      r_sel   <= '0;
      r_last  <= 2'd3;
      r_valid <= 1'b0;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_pick_found) begin
            r_state <= ST_GRANT;
            r_gnt   <= 4'b0001 << w_pick_idx;
            r_sel   <= w_pick_idx;
            r_valid <= 1'b1;
          end
        end
        ST_GRANT: begin
          if (!req[r_sel]) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            r_valid <= 1'b0;
          end else if (w_xfer) begin
            r_cnt <= r_cnt + CW'(1);
            if (!w_hold) begin
              r_last  <= r_sel;
              r_state <= ST_IDLE;
              r_gnt   <= '0;
              r_valid <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_gnt   <= '0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb_mux_rr_arbiter: directed vector table plus hand-written sequences for
// mux_rr_arbiter (W=4, CW=8). Lock sequence is active with MUX_ARB_LOCK_EN.
module tb_mux_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] d0, d1, d2, d3;
  logic       out_ready;
  logic       out_valid;
  logic [3:0] out_data;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic [3:0] ack;
  logic [7:0] xfer_cnt;
`ifdef MUX_ARB_LOCK_EN
  logic [3:0] lock;
`endif

  int n_chk;
  int n_fail;

  mux_rr_arbiter #(.W(4), .CW(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .d0        (d0),
    .d1        (d1),
    .d2        (d2),
    .d3        (d3),
`ifdef MUX_ARB_LOCK_EN
    .lock      (lock),
`endif
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .gnt       (gnt),
    .sel       (sel),
    .ack       (ack),
    .xfer_cnt  (xfer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic [3:0] req;
    logic       rdy;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       vld;
    logic [3:0] data;
    logic [3:0] ack;
    logic [7:0] cnt;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mkv(logic r, logic [3:0] q, logic y, logic [3:0] g,
                               logic [1:0] s, logic v, logic [3:0] dt,
                               logic [3:0] a, logic [7:0] c);
    vec_t t;
    t.rst_n = r; t.req = q; t.rdy = y; t.gnt = g; t.sel = s;
    t.vld = v; t.data = dt; t.ack = a; t.cnt = c;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    d0 = 4'b0001; d1 = 4'b0010; d2 = 4'b0100; d3 = 4'b1000;
    rst_n = 1'b0; req = 4'hF; out_ready = 1'b1;
`ifdef MUX_ARB_LOCK_EN
    lock = 4'h0;
`endif

    //           rst  req    rdy   gnt    sel   vld  data  ack    cnt
    tv.push_back(mkv(0, 4'hF, 1, 4'h0, 2'd0, 0, 4'h0, 4'h0, 8'd0)); // 0 reset 2nd cycle
    tv.push_back(mkv(1, 4'hF, 0, 4'h0, 2'd0, 0, 4'h0, 4'h0, 8'd0)); // 1 released
    tv.push_back(mkv(1, 4'hF, 0, 4'h1, 2'd0, 1, 4'h1, 4'h0, 8'd0)); // 2 grant 0 first
    tv.push_back(mkv(1, 4'hF, 1, 4'h1, 2'd0, 1, 4'h1, 4'h1, 8'd0)); // 3 xfer 0
    tv.push_back(mkv(1, 4'hF, 1, 4'h0, 2'd0, 0, 4'h0, 4'h0, 8'd1)); // 4 bubble
    tv.push_back(mkv(1, 4'hF, 0, 4'h2, 2'd1, 1, 4'h2, 4'h0, 8'd1)); // 5 backpressure x5
    tv.push_back(mkv(1, 4'hF, 0, 4'h2, 2'd1, 1, 4'h2, 4'h0, 8'd1));
    tv.push_back(mkv(1, 4'hF, 0, 4'h2, 2'd1, 1, 4'h2, 4'h0, 8'd1));
    tv.push_back(mkv(1, 4'hF, 0, 4'h2, 2'd1, 1, 4'h2, 4'h0, 8'd1));
    tv.push_back(mkv(1, 4'hF, 0, 4'h2, 2'd1, 1, 4'h2, 4'h0, 8'd1));
    tv.push_back(mkv(1, 4'hF, 1, 4'h2, 2'd1, 1, 4'h2, 4'h2, 8'd1)); // 10 xfer 1
    tv.push_back(mkv(1, 4'hF, 1, 4'h0, 2'd1, 0, 4'h0, 4'h0, 8'd2)); // 11 sel held in idle
    tv.push_back(mkv(1, 4'hF, 1, 4'h4, 2'd2, 1, 4'h4, 4'h4, 8'd2)); // 12 xfer 2
    tv.push_back(mkv(1, 4'hF, 1, 4'h0, 2'd2, 0, 4'h0, 4'h0, 8'd3));
    tv.push_back(mkv(1, 4'hF, 1, 4'h8, 2'd3, 1, 4'h8, 4'h8, 8'd3)); // 14 xfer 3
    tv.push_back(mkv(1, 4'hF, 1, 4'h0, 2'd3, 0, 4'h0, 4'h0, 8'd4));
    tv.push_back(mkv(1, 4'hF, 1, 4'h1, 2'd0, 1, 4'h1, 4'h1, 8'd4)); // 16 wraps to 0
    tv.push_back(mkv(1, 4'h4, 1, 4'h0, 2'd0, 0, 4'h0, 4'h0, 8'd5)); // 17 single req 2
    tv.push_back(mkv(1, 4'h4, 1, 4'h4, 2'd2, 1, 4'h4, 4'h4, 8'd5));
    tv.push_back(mkv(1, 4'h0, 1, 4'h0, 2'd2, 0, 4'h0, 4'h0, 8'd6)); // 19 idle no req
    tv.push_back(mkv(1, 4'h0, 1, 4'h0, 2'd2, 0, 4'h0, 4'h0, 8'd6));
    tv.push_back(mkv(1, 4'h2, 0, 4'h0, 2'd2, 0, 4'h0, 4'h0, 8'd6)); // 21 req 1 only
    tv.push_back(mkv(1, 4'h2, 0, 4'h2, 2'd1, 1, 4'h2, 4'h0, 8'd6));
    tv.push_back(mkv(1, 4'h0, 0, 4'h2, 2'd1, 1, 4'h2, 4'h0, 8'd6)); // 23 drop req -> abort
    tv.push_back(mkv(1, 4'h6, 0, 4'h0, 2'd1, 0, 4'h0, 4'h0, 8'd6)); // 24 last still 2 -> pick 1
    tv.push_back(mkv(1, 4'h6, 0, 4'h2, 2'd1, 1, 4'h2, 4'h0, 8'd6));
    tv.push_back(mkv(0, 4'h6, 0, 4'h2, 2'd1, 1, 4'h2, 4'h0, 8'd6)); // 26 reset mid grant
    tv.push_back(mkv(1, 4'h7, 0, 4'h0, 2'd0, 0, 4'h0, 4'h0, 8'd0));
    tv.push_back(mkv(1, 4'h7, 1, 4'h1, 2'd0, 1, 4'h1, 4'h1, 8'd0)); // 28 grant 0 after reset
    tv.push_back(mkv(1, 4'h0, 0, 4'h0, 2'd0, 0, 4'h0, 4'h0, 8'd1));

    step();
    for (int i = 0; i < tv.size(); i++) begin
      rst_n = tv[i].rst_n;
      req = tv[i].req;
      out_ready = tv[i].rdy;
      #1;
      chk($sformatf("v%0d.gnt", i), 32'(gnt), 32'(tv[i].gnt));
      chk($sformatf("v%0d.sel", i), 32'(sel), 32'(tv[i].sel));
      chk($sformatf("v%0d.out_valid", i), 32'(out_valid), 32'(tv[i].vld));
      chk($sformatf("v%0d.out_data", i), 32'(out_data), 32'(tv[i].data));
      chk($sformatf("v%0d.ack", i), 32'(ack), 32'(tv[i].ack));
      chk($sformatf("v%0d.xfer_cnt", i), 32'(xfer_cnt), 32'(tv[i].cnt));
      step();
    end

    // counter wrap: 254 more transfers to reach 255, then one more to 0
    req = 4'h1;
    out_ready = 1'b1;
    for (int n = 0; n < 254; n++) begin
      step();
      chk("onehot_grant", 32'($countones(gnt)), 32'd1);
      step();
    end
    chk("cnt_255", 32'(xfer_cnt), 32'd255);
    step();
    step();
    chk("cnt_wrap", 32'(xfer_cnt), 32'd0);
    req = 4'h0;
    step();

`ifdef MUX_ARB_LOCK_EN
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    req = 4'h8;
    lock = 4'h8;
    out_ready = 1'b0;
    step();
    chk("lock.first_gnt", 32'(gnt), 32'h8);
    req = 4'h9;
    out_ready = 1'b1;
    for (int t = 0; t < 3; t++) begin
      #1;
      chk($sformatf("lock%0d.gnt", t), 32'(gnt), 32'h8);
      chk($sformatf("lock%0d.ack", t), 32'(ack), 32'h8);
      chk($sformatf("lock%0d.cnt", t), 32'(xfer_cnt), 32'(t));
      step();
    end
    lock = 4'h0;
    #1;
    chk("lock3.ack", 32'(ack), 32'h8);
    step();
    chk("lock.bubble_gnt", 32'(gnt), 32'h0);
    chk("lock.cnt", 32'(xfer_cnt), 32'd4);
    step();
    chk("lock.next_gnt", 32'(gnt), 32'h1);
    chk("lock.next_data", 32'(out_data), 32'h1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
